digital_count_up_watch: RTL
===========================

# digital_count_up_watch

Up-counting stopwatch, the counterpart of the countdown stop watch: it counts elapsed mm:ss from 00:00 toward a programmed limit instead of down to zero. It shares the countdown block's control and time-field conventions (start_stopn, 6-bit minutes/seconds, finish) so both can drive the same display path. It adds a lap-capture register pair, synchronous clear, and an invalid-limit error flag.

## Interface
- TICKS_PER_SEC, default 1: clk cycles per one-second increment (1 = every running cycle is a second; ≥1).
- clk  in  1  rising-edge clock.
- rstn  in  1  asynchronous active-low reset.
- start_stopn  in  1  1 = run, 0 = pause; level-sampled each edge.
- clear  in  1  synchronous clear: count, lap registers and finish to 0, state to IDLE.
- lap  in  1  level; each edge it is 1, lap registers capture the current out value.
- minutes  in  6  limit minutes, valid 0–59.
- seconds  in  6  limit seconds, valid 0–59.
- finish  out  1  registered; 1 while in DONE.
- error  out  1  registered; 1 when the sampled limit is invalid.
- out_minutes  out  6  elapsed minutes, 0–59.
- out_seconds  out  6  elapsed seconds, 0–59.
- lap_minutes  out  6  captured minutes.
- lap_seconds  out  6  captured seconds.

## Operation
- Priority: rstn > clear > state machine; lap capture is independent of state but yields to clear.
- States:
  - IDLE: count 00:00. Goes to RUN on an edge with start_stopn=1 and a valid limit.
  - RUN: counting.
  - PAUSE: count and prescaler hold.
  - DONE: count holds; finish=1. Left only via clear or rstn.
- Limit valid iff minutes≤59 and seconds≤59. error <= !valid on every edge, in every state.
- Invalid limit in IDLE: no start. In RUN: count and prescaler freeze; state stays RUN; counting resumes when the limit becomes valid again.
- RUN, start_stopn=0: go to PAUSE on that edge, no increment.
- PAUSE, start_stopn=1: go to RUN on that edge, no increment. The prescaler phase is retained.
- RUN, start_stopn=1, valid limit:
  - If count ≥ limit (limit lowered, or limit 00:00): go to DONE, no increment.
  - Otherwise the prescaler increments. When it equals TICKS_PER_SEC-1 it returns to 0 and the count increments.
- Count increment: seconds 59→0 with minutes+1; otherwise seconds+1. If the incremented value equals the limit, go to DONE and set finish on the same edge.
- Count comparison is minutes-major: (m1,s1) ≥ (m2,s2) iff m1>m2, or m1==m2 and s1≥s2.
- Minutes never exceed 59 (limit ≤ 59:59 guarantees DONE first).
- Lap: lap_minutes/lap_seconds <= out value before the edge. A lap on the same edge as an increment captures the pre-increment value. Lap is honoured in every state.

## Timing
- Reset values: out_minutes=0, out_seconds=0, lap_minutes=0, lap_seconds=0, finish=0, error=0, prescaler=0, state IDLE.
- The start edge (IDLE→RUN) does not count. With TICKS_PER_SEC=1, the first increment is on the next edge and limit L seconds is reached L edges after entering RUN.
- Clear or a lowered limit while in DONE: clear returns to IDLE next edge. A limit change in DONE has no effect.
- finish rises on the same edge that out_* first equals the limit; it falls only on the clear edge or at reset.
- Start with limit 00:00: IDLE→RUN edge, then RUN→DONE on the next edge, finish=1 with out 00:00.
- Reset mid-operation: all registers return to reset values immediately, independent of clk.

## Test plan
- Reset: assert rstn=0 mid-run at 00:17 → all outputs 0 immediately, state IDLE; release, start_stopn=0 → outputs stay 0.
- Full count, TICKS=1, limit 01:24, start_stopn=1 → out 00:59→01:00 on the 60th increment; out=01:24 with finish=1 on edge 84; holds afterwards.
- Pause/resume: run to 00:10, start_stopn=0 for 5 cycles → out holds 00:10; start_stopn=1 → resume edge keeps 00:10, next edge 00:11.
- Invalid limit: running at 00:20, minutes=63 → error=1 next edge, count frozen at 00:20, finish=0; minutes=1 → error=0, counting resumes.
- Lap and clear: lap=1 for one cycle at 00:30 → lap regs 00:30, count continues to 00:31; clear=1 → all outputs 0, IDLE.
- Prescale, TICKS_PER_SEC=4: seconds advance every 4 running cycles. Pause after 2 prescale cycles and resume → next increment 2 running cycles later.

Source files
------------

// File: rtl/digital_count_up_watch.sv
// Up-counting mm:ss stopwatch with a programmable limit, lap capture,
// synchronous clear and an invalid-limit error flag.
module digital_count_up_watch #(
  parameter int unsigned TICKS_PER_SEC = 1
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       start_stopn,
  input  logic       clear,
  input  logic       lap,
  input  logic [5:0] minutes,
  input  logic [5:0] seconds,
  output logic       finish,
  output logic       error,
  output logic [5:0] out_minutes,
  output logic [5:0] out_seconds,
  output logic [5:0] lap_minutes,
  output logic [5:0] lap_seconds
);

  localparam int unsigned PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [5:0]      min_q, min_d;
  logic [5:0]      sec_q, sec_d;
  logic [5:0]      lap_min_q, lap_min_d;
  logic [5:0]      lap_sec_q, lap_sec_d;
  logic            finish_q, finish_d;
  logic            error_q, error_d;

  logic            limit_valid;
  logic            at_limit;
  logic [5:0]      inc_min;
  logic [5:0]      inc_sec;
  logic            inc_hits_limit;
  logic            presc_wrap;

  assign limit_valid = (minutes <= 6'd59) && (seconds <= 6'd59);

  // Minutes-major compare: catches a limit lowered below the running count.
  assign at_limit = (min_q > minutes) || ((min_q == minutes) && (sec_q >= seconds));

  always_comb begin
    inc_min = min_q;
    inc_sec = sec_q + 6'd1;
    if (sec_q == 6'd59) begin
      inc_sec = '0;
      inc_min = min_q + 6'd1;
    end
  end

  assign inc_hits_limit = (inc_min == minutes) && (inc_sec == seconds);
  assign presc_wrap     = (presc_q == PRESC_LAST);

  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    min_d     = min_q;
    sec_d     = sec_q;
    lap_min_d = lap_min_q;
    lap_sec_d = lap_sec_q;
    error_d   = ~limit_valid;

    if (clear) begin
      state_d   = IDLE;
      presc_d   = '0;
      min_d     = '0;
      sec_d     = '0;
      lap_min_d = '0;
      lap_sec_d = '0;
    end else begin
      if (lap) begin
        lap_min_d = min_q;
        lap_sec_d = sec_q;
      end

      unique case (state_q)
        IDLE: begin
          presc_d = '0;
          min_d   = '0;
          sec_d   = '0;
          if (start_stopn && limit_valid) begin
            state_d = RUN;
          end
        end

        RUN: begin
          if (!start_stopn) begin
            state_d = PAUSE;
          end else if (limit_valid) begin
            if (at_limit) begin
              state_d = DONE;
            end else if (presc_wrap) begin
              presc_d = '0;
              min_d   = inc_min;
              sec_d   = inc_sec;
              if (inc_hits_limit) begin
                state_d = DONE;
              end
            end else begin
              presc_d = presc_q + PW'(1);
            end
          end
        end

        PAUSE: begin
          if (start_stopn) begin
            state_d = RUN;
          end
        end

        DONE: begin
          state_d = DONE;
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end

    finish_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      presc_q   <= '0;
      min_q     <= '0;
      sec_q     <= '0;
      lap_min_q <= '0;
      lap_sec_q <= '0;
      finish_q  <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      min_q     <= min_d;
      sec_q     <= sec_d;
      lap_min_q <= lap_min_d;
      lap_sec_q <= lap_sec_d;
      finish_q  <= finish_d;
      error_q   <= error_d;
    end
  end

  assign finish      = finish_q;
  assign error       = error_q;
  assign out_minutes = min_q;
  assign out_seconds = sec_q;
  assign lap_minutes = lap_min_q;
  assign lap_seconds = lap_sec_q;

endmodule
